rng_uni_ctrl: RTL

Sequencer for the 32-bit uniform RNG core (`rng_uni`). It loads a 1024-bit seed into the core's serial seed chain from a 32-bit word stream. It then runs a fixed warm-up in generate mode and presents random words to one consumer over a valid/ready handshake. It sits between the seed/control interface and the `rng_uni` instance and is the only driver of its `ce`, `mode` and `s_in` inputs.

---
 rtl/rng_uni_pkg.sv | 14 +
 rtl/rng_uni_ctrl_ser.sv | 89 ++++++++
 rtl/rng_uni_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rng_uni_pkg.sv
// Shared types and constants for the rng_uni core and its sequencer.
package rng_uni_pkg;

    localparam int RNG_UNI_SEED_LEN = 1024;
    localparam int RNG_UNI_WIDTH    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WARM = 2'd2,
        RUN  = 2'd3
    } rng_uni_ctrl_state_t;

endpackage

// File: rtl/rng_uni_ctrl_ser.sv
// Seed word serializer for rng_uni_ctrl: 32-bit load/shift buffer, LSB first.
// Readback collector on gen_s_out is built only when RNG_UNI_CTRL_READBACK_EN is defined.
module rng_uni_ctrl_ser
    import rng_uni_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     load,
    input  logic [RNG_UNI_WIDTH-1:0] load_data,
    input  logic                     s_out,
    output logic                     shift,
    output logic                     s_bit,
    output logic                     empty,
    output logic                     last,
    output logic [RNG_UNI_WIDTH-1:0] rb_data,
    output logic                     rb_valid
);

    localparam int CW = $clog2(RNG_UNI_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(RNG_UNI_WIDTH - 1);

    logic [RNG_UNI_WIDTH-1:0] buf_reg;
    logic [CW-1:0]            cnt_reg;
    logic                     full_reg;

    assign shift = full_reg;
    assign s_bit = buf_reg[0];
    assign empty = !full_reg;
    assign last  = full_reg && (cnt_reg == LAST_BIT);

    // A load on the last-bit cycle replaces the buffer so words stream back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_reg  <= '0;
            cnt_reg  <= '0;
            full_reg <= 1'b0;
        end else if (clear) begin
            buf_reg  <= '0;
            cnt_reg  <= '0;
            full_reg <= 1'b0;
        end else if (load) begin
            buf_reg  <= load_data;
            cnt_reg  <= '0;
            full_reg <= 1'b1;
        end else if (full_reg) begin
            buf_reg <= buf_reg >> 1;
            if (last) begin
                full_reg <= 1'b0;
                cnt_reg  <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

`ifdef RNG_UNI_CTRL_READBACK_EN
    logic [RNG_UNI_WIDTH-1:0] col_reg;
    logic [RNG_UNI_WIDTH-1:0] rb_data_reg;
    logic                     rb_valid_reg;

    // Collector is word-aligned with the shift buffer, so the buffer's last flag closes each word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg      <= '0;
            rb_data_reg  <= '0;
            rb_valid_reg <= 1'b0;
        end else begin
            rb_valid_reg <= 1'b0;
            if (full_reg) begin
                col_reg <= {s_out, col_reg[RNG_UNI_WIDTH-1:1]};
                if (last) begin
                    rb_data_reg  <= {s_out, col_reg[RNG_UNI_WIDTH-1:1]};
                    rb_valid_reg <= 1'b1;
                end
            end
        end
    end

    assign rb_data  = rb_data_reg;
    assign rb_valid = rb_valid_reg;
`else
    logic unused_s_out;
    assign unused_s_out = s_out;
    assign rb_data      = '0;
    assign rb_valid     = 1'b0;
`endif

endmodule

// File: rtl/rng_uni_ctrl.sv
// Sequencer for the rng_uni core: seed load, warm-up, then valid/ready word delivery.
// Optional seed-chain readback is enabled by defining RNG_UNI_CTRL_READBACK_EN.
module rng_uni_ctrl
    import rng_uni_pkg::*;
#(
    parameter int SEED_LEN = RNG_UNI_SEED_LEN,
    parameter int WARMUP   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] seed_data,
    input  logic        seed_valid,
    output logic        seed_ready,
    output logic        gen_ce,
    output logic        gen_mode,
    output logic        gen_s_in,
    input  logic        gen_s_out,
    input  logic [31:0] gen_rng,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic [31:0] rb_data,
    output logic        rb_valid
);

    localparam int NWORDS = SEED_LEN / RNG_UNI_WIDTH;
    localparam int WCW    = $clog2(NWORDS + 1);
    localparam int WMW    = $clog2(WARMUP + 1);
    localparam logic [WCW-1:0] NWORDS_W  = WCW'(NWORDS);
    localparam logic [WMW-1:0] WARM_LAST = WMW'(WARMUP - 1);

    rng_uni_ctrl_state_t state_reg, state_next;
    logic [WCW-1:0]      word_cnt_reg, word_cnt_next;
    logic [WMW-1:0]      warm_cnt_reg, warm_cnt_next;
    logic                out_valid_reg, out_valid_next;

    logic ser_clear;
    logic ser_load;
    logic ser_shift;
    logic ser_bit;
    logic ser_empty;
    logic ser_last;

    assign ser_load  = seed_valid && seed_ready;
    assign out_data  = gen_rng;
    assign out_valid = out_valid_reg;

    rng_uni_ctrl_ser u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (ser_clear),
        .load      (ser_load),
        .load_data (seed_data),
        .s_out     (gen_s_out),
        .shift     (ser_shift),
        .s_bit     (ser_bit),
        .empty     (ser_empty),
        .last      (ser_last),
        .rb_data   (rb_data),
        .rb_valid  (rb_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            word_cnt_reg  <= '0;
            warm_cnt_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            word_cnt_reg  <= word_cnt_next;
            warm_cnt_reg  <= warm_cnt_next;
            out_valid_reg <= out_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        word_cnt_next  = word_cnt_reg;
        warm_cnt_next  = warm_cnt_reg;
        out_valid_next = 1'b0;
        ser_clear      = 1'b0;
        seed_ready     = 1'b0;
        gen_ce         = 1'b0;
        gen_mode       = 1'b0;
        gen_s_in       = 1'b0;
        busy           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = LOAD;
                    ser_clear     = 1'b1;
                    word_cnt_next = '0;
                end
            end

            LOAD: begin
                busy       = 1'b1;
                gen_mode   = 1'b1;
                // Stop accepting once the full seed has been taken; the buffer still drains.
                seed_ready = (ser_empty || ser_last) && (word_cnt_reg != NWORDS_W);
                gen_ce     = ser_shift;
                gen_s_in   = ser_shift && ser_bit;
                if (seed_valid && seed_ready) begin
                    word_cnt_next = word_cnt_reg + 1'b1;
                end
                if (ser_last && (word_cnt_reg == NWORDS_W)) begin
                    state_next    = WARM;
                    warm_cnt_next = '0;
                end
            end

            WARM: begin
                busy   = 1'b1;
                gen_ce = 1'b1;
                if (warm_cnt_reg == WARM_LAST) begin
                    state_next = RUN;
                end else begin
                    warm_cnt_next = warm_cnt_reg + 1'b1;
                end
            end

            RUN: begin
                // Advancing the core only when the held word is free keeps out_data stable under stall.
                gen_ce = !out_valid_reg || out_ready;
                if (start) begin
                    state_next     = LOAD;
                    ser_clear      = 1'b1;
                    word_cnt_next  = '0;
                    out_valid_next = 1'b0;
                end else if (gen_ce) begin
                    out_valid_next = 1'b1;
                end else begin
                    out_valid_next = out_valid_reg && !out_ready;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
